inhibitor_sweep_ctrl: RTL and testbench

- Sequencer wrapped around the network-simulation datapath (the unit with start / ld_inhibitor / sel_inhibitor / steady_state / iteration_number).
- On a single go pulse, runs one simulation per rule index from FIRST_RULE to LAST_RULE. Each run loads that rule as inhibitor, starts from the same initial state and waits for steady state or iteration timeout.
- Emits one result record per run over a valid/ready stream; the host collects knockout effects without per-run software intervention.

---
 rtl/sweep_pkg.sv | 28 ++
 rtl/sweep_result_reg.sv | 27 ++
 rtl/inhibitor_sweep_ctrl.sv | 179 +++++++++++++++++
 tb/tb_inhibitor_sweep_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared types and constants for the inhibitor sweep sequencer
package sweep_pkg;

  localparam int SW_STATE_W   = 32;
  localparam int SW_LOG_RULES = 5;
  localparam int SW_ITER_W    = 10;

  // The datapath steady flag may still reflect the previous run this long after start.
  localparam logic [1:0] SETTLE_CYCLES = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    SETTLE,
    RUN,
    EMIT,
    FIN
  } sweep_state_t;

  typedef struct packed {
    logic [SW_LOG_RULES-1:0] rule;
    logic [SW_STATE_W-1:0]   state;
    logic [SW_ITER_W-1:0]    iters;
    logic                    timeout;
  } result_t;

endpackage

// File: rtl/sweep_result_reg.sv
// rtl/sweep_result_reg.sv - one-entry valid/ready holding register for sweep result records
module sweep_result_reg
  import sweep_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  result_t data_in,
  output logic    valid,
  input  logic    ready,
  output result_t data_out
);

  // The sequencer only loads while the entry is empty, so load never collides with a pending record.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid    <= 1'b0;
      data_out <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      data_out <= data_in;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/inhibitor_sweep_ctrl.sv
// rtl/inhibitor_sweep_ctrl.sv - rule-by-rule knockout sweep sequencer around the network datapath
// Optional INHIB_SKIP_MASK_EN adds a per-rule skip mask captured on go.
module inhibitor_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int STATE_W   = SW_STATE_W,
  parameter int LOG_RULES = SW_LOG_RULES,
  parameter int MAX_ITER  = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [LOG_RULES-1:0] first_rule,
  input  logic [LOG_RULES-1:0] last_rule,
  input  logic [STATE_W-1:0]   init_state,
`ifdef INHIB_SKIP_MASK_EN
  input  logic [2**LOG_RULES-1:0] skip_mask,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 dp_start,
  output logic                 dp_ld_inhibitor,
  output logic [LOG_RULES-1:0] dp_sel_inhibitor,
  output logic [STATE_W-1:0]   dp_initial_state,
  input  logic                 dp_steady_state,
  input  logic [STATE_W-1:0]   dp_network_state,
  input  logic [9:0]           dp_iteration_number,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [LOG_RULES-1:0] res_rule,
  output logic [STATE_W-1:0]   res_state,
  output logic [9:0]           res_iters,
  output logic                 res_timeout
);

  localparam logic [SW_ITER_W-1:0] ITER_LIMIT = SW_ITER_W'(MAX_ITER);
  localparam logic [LOG_RULES-1:0] RULE_ONE   = LOG_RULES'(1);

  sweep_state_t         state;
  logic [LOG_RULES-1:0] cur;
  logic [LOG_RULES-1:0] last_r;
  logic [1:0]           settle_cnt;
`ifdef INHIB_SKIP_MASK_EN
  logic [2**LOG_RULES-1:0] skip_r;
`endif

  logic    rec_push;
  result_t rec_in;
  result_t rec_out;

  // Steady takes priority over the iteration limit, so a same-cycle hit is not a timeout.
  always_comb begin
    rec_push       = (state == RUN) && (dp_steady_state || (dp_iteration_number >= ITER_LIMIT));
    rec_in.rule    = cur;
    rec_in.state   = dp_network_state;
    rec_in.iters   = dp_iteration_number;
    rec_in.timeout = !dp_steady_state;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      cur              <= '0;
      last_r           <= '0;
      settle_cnt       <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      dp_start         <= 1'b0;
      dp_ld_inhibitor  <= 1'b0;
      dp_sel_inhibitor <= '0;
      dp_initial_state <= '0;
`ifdef INHIB_SKIP_MASK_EN
      skip_r           <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            cur              <= first_rule;
            last_r           <= last_rule;
            dp_initial_state <= init_state;
            busy             <= 1'b1;
`ifdef INHIB_SKIP_MASK_EN
            skip_r           <= skip_mask;
`endif
            if (last_rule < first_rule) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
`ifdef INHIB_SKIP_MASK_EN
              // EMIT with an empty result register doubles as the skip scanner.
              state <= EMIT;
`else
              state            <= LOAD;
              dp_ld_inhibitor  <= 1'b1;
              dp_sel_inhibitor <= first_rule;
`endif
            end
          end
        end
        LOAD: begin
          dp_ld_inhibitor <= 1'b0;
          dp_start        <= 1'b1;
          state           <= START;
        end
        START: begin
          dp_start   <= 1'b0;
          settle_cnt <= '0;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_CYCLES - 2'd1) begin
            state <= RUN;
          end else begin
            settle_cnt <= settle_cnt + 2'd1;
          end
        end
        RUN: begin
          if (rec_push) begin
            state <= EMIT;
          end
        end
        EMIT: begin
          if (res_valid) begin
            if (res_ready) begin
              if (cur == last_r) begin
                state <= FIN;
                done  <= 1'b1;
              end else begin
                cur <= cur + RULE_ONE;
`ifndef INHIB_SKIP_MASK_EN
                state            <= LOAD;
                dp_ld_inhibitor  <= 1'b1;
                dp_sel_inhibitor <= cur + RULE_ONE;
`endif
              end
            end
          end
`ifdef INHIB_SKIP_MASK_EN
          else if (skip_r[cur]) begin
            if (cur == last_r) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              cur <= cur + RULE_ONE;
            end
          end else begin
            state            <= LOAD;
            dp_ld_inhibitor  <= 1'b1;
            dp_sel_inhibitor <= cur;
          end
`endif
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sweep_result_reg u_result (
    .clk      (clk),
    .rst      (rst),
    .load     (rec_push),
    .data_in  (rec_in),
    .valid    (res_valid),
    .ready    (res_ready),
    .data_out (rec_out)
  );

  assign res_rule    = rec_out.rule;
  assign res_state   = rec_out.state;
  assign res_iters   = rec_out.iters;
  assign res_timeout = rec_out.timeout;

endmodule

// File: tb/tb_inhibitor_sweep_ctrl.sv
// tb/tb_inhibitor_sweep_ctrl.sv - scoreboard bench for inhibitor_sweep_ctrl with a datapath model
module tb_inhibitor_sweep_ctrl;
  import sweep_pkg::*;

  localparam int MAX_ITER = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, go, busy, done, dp_start, dp_ld_inhibitor;
  logic [4:0]  first_rule, last_rule, dp_sel_inhibitor, res_rule;
  logic [31:0] init_state, dp_initial_state, dp_network_state, res_state;
  logic        dp_steady_state, res_valid, res_ready, res_timeout;
  logic [9:0]  dp_iteration_number, res_iters;
`ifdef INHIB_SKIP_MASK_EN
  logic [31:0] skip_mask = '0;
`endif

  inhibitor_sweep_ctrl #(.STATE_W(32), .LOG_RULES(5), .MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .rst(rst), .go(go), .first_rule(first_rule), .last_rule(last_rule),
    .init_state(init_state),
`ifdef INHIB_SKIP_MASK_EN
    .skip_mask(skip_mask),
`endif
    .busy(busy), .done(done), .dp_start(dp_start), .dp_ld_inhibitor(dp_ld_inhibitor),
    .dp_sel_inhibitor(dp_sel_inhibitor), .dp_initial_state(dp_initial_state),
    .dp_steady_state(dp_steady_state), .dp_network_state(dp_network_state),
    .dp_iteration_number(dp_iteration_number), .res_valid(res_valid), .res_ready(res_ready),
    .res_rule(res_rule), .res_state(res_state), .res_iters(res_iters), .res_timeout(res_timeout)
  );

  typedef struct {
    int          rule;
    logic [31:0] state;
    int          iters;
    bit          timeout;
  } exp_t;

  exp_t        exp_q[$];
  int          sel_q[$];
  exp_t        e;
  int          checks = 0, errors = 0, done_cnt = 0;
  int          settle_at = 7;
  bit          stale_en = 1'b0;
  logic [31:0] cur_init = '0;

  // Datapath model: counter restarts on dp_start and saturates; steady from iteration settle_at on.
  logic [9:0] iter = '0;
  logic [4:0] model_rule = '0;
  always @(posedge clk) begin
    if (dp_ld_inhibitor) model_rule <= dp_sel_inhibitor;
    if (dp_start) iter <= '0;
    else if (iter != 10'h3ff) iter <= iter + 10'd1;
  end
  assign dp_iteration_number = iter;
  assign dp_steady_state = (settle_at >= 0 && int'(iter) >= settle_at) || (stale_en && iter < 10'd2);
  assign dp_network_state = dp_initial_state ^ ({27'd0, model_rule} << 16) ^ {22'd0, iter};

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: records, load/start sequencing, backpressure stability, done pulses.
  logic        prev_ld = 1'b0, prev_v = 1'b0, prev_r = 1'b0;
  logic [47:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      if (done) done_cnt++;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_record: got rule %0d expected none", res_rule);
        end else begin
          e = exp_q.pop_front();
          chk("rec_rule", 64'(res_rule), 64'(e.rule));
          chk("rec_state", 64'(res_state), 64'(e.state));
          chk("rec_iters", 64'(res_iters), 64'(e.iters));
          chk("rec_timeout", 64'(res_timeout), 64'(e.timeout));
        end
      end
      if (dp_ld_inhibitor) begin
        if (sel_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_load: got sel %0d expected none", dp_sel_inhibitor);
        end else begin
          chk("ld_sel", 64'(dp_sel_inhibitor), 64'(sel_q.pop_front()));
        end
        chk("ld_while_pending", 64'(res_valid), 64'd0);
        chk("init_state_out", 64'(dp_initial_state), 64'(cur_init));
      end
      if (prev_ld) chk("start_after_ld", 64'({dp_start, dp_ld_inhibitor}), 64'(2'b10));
      if (prev_v && !prev_r)
        chk("hold_stable", 64'({res_valid, res_rule, res_state, res_iters, res_timeout}),
            64'({1'b1, prev_data}));
      prev_ld   = dp_ld_inhibitor;
      prev_v    = res_valid;
      prev_r    = res_ready;
      prev_data = {res_rule, res_state, res_iters, res_timeout};
    end else begin
      prev_ld = 1'b0;
      prev_v  = 1'b0;
    end
  end

  task automatic expect_run(int rule, int settle, logic [31:0] init);
    exp_t x;
    x.rule = rule;
    if (settle < 0 || settle > MAX_ITER) begin
      x.iters = MAX_ITER; x.timeout = 1'b1;
    end else begin
      x.iters = settle; x.timeout = 1'b0;
    end
    x.state = init ^ (32'(rule) << 16) ^ 32'(x.iters);
    exp_q.push_back(x);
    sel_q.push_back(rule);
  endtask

  task automatic pulse_go(int f, int l, logic [31:0] init);
    first_rule = 5'(f);
    last_rule  = 5'(l);
    init_state = init;
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
  endtask

  task automatic wait_done(string name, int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    chk({name, "_done_seen"}, 64'(seen), 64'd1);
    @(negedge clk);
    chk({name, "_idle"}, 64'(busy), 64'd0);
    chk({name, "_done_count"}, 64'(done_cnt), 64'd1);
    chk({name, "_records_left"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_loads_left"}, 64'(sel_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1'b0; go = 1'b0; res_ready = 1'b1;
    first_rule = '0; last_rule = '0; init_state = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({busy, done, dp_start, dp_ld_inhibitor, res_valid, res_timeout,
                           dp_sel_inhibitor, res_rule, res_iters}), 64'd0);
    chk("reset_data", 64'({dp_initial_state, res_state}), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // rules 2..4 settle at 7; stale steady during SETTLE must be ignored
    done_cnt = 0; stale_en = 1'b1; settle_at = 7; cur_init = 32'hDEAD_BEEF;
    for (int r = 2; r <= 4; r++) expect_run(r, 7, cur_init);
    pulse_go(2, 4, cur_init);
    chk("busy_after_go", 64'(busy), 64'd1);
    wait_done("sweep_2_4", 200);
    stale_en = 1'b0;

    // never steady: both runs time out at MAX_ITER
    done_cnt = 0; settle_at = -1; cur_init = 32'h1234_5678;
    expect_run(5, -1, cur_init);
    expect_run(6, -1, cur_init);
    pulse_go(5, 6, cur_init);
    wait_done("timeout", 3000);

    // steady in the same cycle as the limit: not a timeout
    done_cnt = 0; settle_at = MAX_ITER; cur_init = 32'h0F0F_0000;
    expect_run(7, MAX_ITER, cur_init);
    pulse_go(7, 7, cur_init);
    wait_done("steady_at_limit", 1500);

    // backpressure: hold res_ready low for 20 cycles on the first record
    done_cnt = 0; settle_at = 7; cur_init = 32'hCAFE_0001;
    expect_run(0, 7, cur_init);
    expect_run(1, 7, cur_init);
    @(posedge clk); #1 res_ready = 1'b0;
    @(negedge clk);
    pulse_go(0, 1, cur_init);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (res_valid) begin found = 1'b1; break; end
    end
    chk("stall_valid_seen", 64'(found), 64'd1);
    repeat (20) @(negedge clk);
    @(posedge clk); #1 res_ready = 1'b1;
    wait_done("backpressure", 200);

    // reset during RUN of rule 3 aborts without record or done
    done_cnt = 0; cur_init = 32'h5555_AAAA;
    expect_run(2, 7, cur_init);
    sel_q.push_back(3);
    pulse_go(2, 5, cur_init);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dp_ld_inhibitor && dp_sel_inhibitor == 5'd3) begin found = 1'b1; break; end
    end
    chk("reset_rule3_load_seen", 64'(found), 64'd1);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrun_reset_ctrl", 64'({busy, done, dp_start, dp_ld_inhibitor, res_valid, res_timeout,
                                  dp_sel_inhibitor, res_rule, res_iters}), 64'd0);
    chk("midrun_reset_data", 64'({dp_initial_state, res_state}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrun_no_done", 64'(done_cnt), 64'd0);
    chk("midrun_records_left", 64'(exp_q.size()), 64'd0);
    chk("midrun_loads_left", 64'(sel_q.size()), 64'd0);

    // clean restart; a second go while busy is ignored
    done_cnt = 0; cur_init = 32'h0000_00FF;
    expect_run(1, 7, cur_init);
    pulse_go(1, 1, cur_init);
    repeat (3) @(negedge clk);
    pulse_go(9, 12, 32'hFFFF_0000);
    wait_done("go_while_busy", 200);

    // empty range: no runs, done still pulses
    done_cnt = 0;
    pulse_go(6, 3, 32'h0BAD_F00D);
    wait_done("empty_range", 20);

`ifdef INHIB_SKIP_MASK_EN
    done_cnt = 0; cur_init = 32'h7777_0000; skip_mask = 32'h5;
    expect_run(1, 7, cur_init);
    expect_run(3, 7, cur_init);
    pulse_go(0, 3, cur_init);
    wait_done("skip_mask", 200);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
